// File: rtl/stack_arbiter.sv
// Round-robin arbiter that shares one LIFO stack between NREQ requesters, running one
// push or pop at a time and rejecting pushes to a full stack or pops from an empty one.
module stack_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned DW   = 16,
  parameter int unsigned IW   = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    req_rw,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    ack,
  output logic [NREQ-1:0]    err,
  output logic [DW-1:0]      rd_data,
  output logic               busy,
  output logic [DW-1:0]      stk_data_in,
  output logic               stk_read_write,
  output logic               stk_enable,
  input  logic [DW-1:0]      stk_data_out,
  input  logic               stk_e_flag,
  input  logic               stk_f_flag
);

  typedef enum logic [1:0] {StIdle, StIssue, StCapt, StResp} state_e;

  state_e            state_q, state_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [IW-1:0]     gnt_q, gnt_d;
  logic              op_q, op_d;
  logic [DW-1:0]     data_q, data_d;
  logic              rej_q, rej_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic [NREQ-1:0]   err_q, err_d;
  logic [DW-1:0]     rd_data_q, rd_data_d;
  logic              busy_q, busy_d;
  logic              en_q, en_d;

  logic              arb_found;
  logic [IW-1:0]     arb_pick;
  logic [IW-1:0]     cand;
  logic              sel_rw;
  logic [DW-1:0]     sel_data;
  logic [NREQ-1:0]   gnt_oh;

  // First requesting index at or above the rr pointer, wrapping around.
  always_comb begin
    arb_found = 1'b0;
    arb_pick  = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = IW'((32'(ptr_q) + k) % NREQ);
      if (!arb_found && req[cand]) begin
        arb_found = 1'b1;
        arb_pick  = cand;
      end
    end
  end

  always_comb begin
    sel_rw   = 1'b0;
    sel_data = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (arb_pick == IW'(k)) begin
        sel_rw   = req_rw[k];
        sel_data = req_data[k*DW +: DW];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    op_d      = op_q;
    data_d    = data_q;
    rej_d     = rej_q;
    rd_data_d = rd_data_q;
    ack_d     = '0;
    err_d     = '0;
    gnt_oh    = '0;

    unique case (state_q)
      StIdle: begin
        if (arb_found) begin
          gnt_d  = arb_pick;
          op_d   = sel_rw;
          data_d = sel_data;
          if ((!sel_rw && stk_f_flag) || (sel_rw && stk_e_flag)) begin
            rej_d   = 1'b1;
            state_d = StResp;
          end else begin
            rej_d   = 1'b0;
            state_d = StIssue;
          end
        end
      end
      StIssue: state_d = op_q ? StCapt : StResp;
      StCapt: begin
        rd_data_d = stk_data_out;
        state_d   = StResp;
      end
      StResp: begin
        ptr_d   = (32'(gnt_q) == NREQ - 1) ? '0 : gnt_q + IW'(1);
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Outputs are registered, so they are decoded from the state being entered.
    gnt_oh = NREQ'(1) << gnt_d;
    if (state_d == StResp) begin
      ack_d = rej_d ? '0 : gnt_oh;
      err_d = rej_d ? gnt_oh : '0;
    end
    en_d   = (state_d == StIssue);
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      gnt_q     <= '0;
      op_q      <= 1'b0;
      data_q    <= '0;
      rej_q     <= 1'b0;
      ack_q     <= '0;
      err_q     <= '0;
      rd_data_q <= '0;
      busy_q    <= 1'b0;
      en_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      op_q      <= op_d;
      data_q    <= data_d;
      rej_q     <= rej_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      rd_data_q <= rd_data_d;
      busy_q    <= busy_d;
      en_q      <= en_d;
    end
  end

  assign ack            = ack_q;
  assign err            = err_q;
  assign rd_data        = rd_data_q;
  assign busy           = busy_q;
  assign stk_enable     = en_q;
  assign stk_read_write = op_q;
  assign stk_data_in    = data_q;

endmodule

// File: tb/tb_stack_arbiter.sv
// Bench for stack_arbiter: a behavioural stack device, a queue-based reference model with
// round-robin ordering, and a scoreboard monitor that checks every ack/err pulse.
module tb_stack_arbiter;
  localparam int NREQ  = 4;
  localparam int DW    = 16;
  localparam int IW    = 2;
  localparam int DEPTH = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ-1:0]   req_rw = '0;
  logic [NREQ*DW-1:0] req_data = '0;
  logic [NREQ-1:0]   ack, err;
  logic [DW-1:0]     rd_data;
  logic              busy;
  logic [DW-1:0]     stk_data_in;
  logic              stk_read_write, stk_enable;
  logic [DW-1:0]     stk_data_out = '0;
  logic              stk_e_flag, stk_f_flag;

  stack_arbiter #(.NREQ(NREQ), .DW(DW), .IW(IW)) dut (
    .clk(clk), .reset(reset), .req(req), .req_rw(req_rw), .req_data(req_data),
    .ack(ack), .err(err), .rd_data(rd_data), .busy(busy),
    .stk_data_in(stk_data_in), .stk_read_write(stk_read_write), .stk_enable(stk_enable),
    .stk_data_out(stk_data_out), .stk_e_flag(stk_e_flag), .stk_f_flag(stk_f_flag)
  );

  always #5 clk = ~clk;

  // Stack device: independent of the arbiter's reset.
  logic [DW-1:0] mem [DEPTH];
  logic [3:0]    sp = '0;
  int            en_count = 0;
  int            cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (stk_enable) begin
      en_count <= en_count + 1;
      if (!stk_read_write) begin
        if (sp < 4'(DEPTH)) begin
          mem[sp[2:0]] <= stk_data_in;
          sp <= sp + 4'd1;
        end
      end else if (sp > 4'd0) begin
        stk_data_out <= mem[3'(sp - 4'd1)];
        sp <= sp - 4'd1;
      end
    end
  end
  assign stk_e_flag = (sp == 4'd0);
  assign stk_f_flag = (sp == 4'(DEPTH));

  typedef struct {
    int            id;
    bit            rej;
    logic [DW-1:0] rd;
    int            issue;
    int            lat;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] model[$];
  logic [DW-1:0] last_pop = '0;
  int            ptr_m = 0;
  int            n_checks = 0;
  int            n_fail = 0;
  int            last_en = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every response pulse is matched against the head of the scoreboard.
  initial forever begin
    exp_t            e;
    logic [NREQ-1:0] ev;
    @(negedge clk);
    if (reset && stk_enable) begin
      if (last_en >= 0) check("enable gap >= 3", 32'(cyc - last_en >= 3), 32'(1));
      last_en = cyc;
    end
    if (reset && (ack != '0 || err != '0)) begin
      check("pulse onehot", 32'(((ack | err) & ((ack | err) - 4'd1)) == '0 && (ack & err) == '0),
            32'(1));
      if (sb.size() == 0) begin
        check("unexpected pulse", 32'({ack, err}), 32'(0));
      end else begin
        e  = sb.pop_front();
        ev = 4'(1) << e.id;
        check("ack vector", 32'(ack), 32'(e.rej ? 4'd0 : ev));
        check("err vector", 32'(err), 32'(e.rej ? ev : 4'd0));
        check("rd_data", 32'(rd_data), 32'(e.rd));
        check("busy in resp", 32'(busy), 32'(1));
        if (e.lat >= 0) check("latency", 32'(cyc - e.issue), 32'(e.lat));
      end
    end
  end

  // Raise a set of requests together; the model fixes grant order and expected results.
  task automatic run_set(input logic [NREQ-1:0] mask, input logic [NREQ-1:0] rw,
                         input logic [NREQ*DW-1:0] data, input bit scramble);
    exp_t            e;
    int              cur, first, n_en, en0, t;
    logic [NREQ-1:0] pending;
    logic [DW-1:0]   d;
    @(posedge clk);
    #1;
    cur   = ptr_m;
    first = -1;
    n_en  = 0;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (cur + k) % NREQ;
      if (mask[idx]) begin
        e.id    = idx;
        e.issue = cyc;
        e.lat   = -1;
        d       = data[idx*DW +: DW];
        if (rw[idx]) begin
          if (model.size() == 0) e.rej = 1'b1;
          else begin
            e.rej    = 1'b0;
            last_pop = model.pop_back();
            n_en++;
          end
        end else begin
          if (model.size() == DEPTH) e.rej = 1'b1;
          else begin
            e.rej = 1'b0;
            model.push_back(d);
            n_en++;
          end
        end
        e.rd = last_pop;
        if (first < 0) begin
          first = idx;
          e.lat = e.rej ? 1 : (rw[idx] ? 3 : 2);
        end
        sb.push_back(e);
        ptr_m = (idx + 1) % NREQ;
      end
    end
    en0      = en_count;
    req_data = data;
    req_rw   = rw;
    req      = mask;
    if (scramble && first >= 0) begin
      @(posedge clk);
      #1;
      req_data[first*DW +: DW] = ~req_data[first*DW +: DW];
      req_rw[first]            = ~req_rw[first];
    end
    pending = mask;
    t = 0;
    while (pending != '0 && t < 200) begin
      @(negedge clk);
      pending = pending & ~(ack | err);
      req     = req & ~(ack | err);
      t++;
    end
    if (pending != '0) begin
      check("response timeout", 32'(pending), 32'(0));
      req = '0;
    end
    check("stack op count", 32'(en_count - en0), 32'(n_en));
  endtask

  task automatic one(input int id, input bit rw, input logic [DW-1:0] d);
    logic [NREQ*DW-1:0] dv;
    logic [NREQ-1:0]    m;
    logic [NREQ-1:0]    r;
    dv = '0;
    dv[id*DW +: DW] = d;
    m = 4'(1) << id;
    r = rw ? m : '0;
    run_set(m, r, dv, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    logic [NREQ*DW-1:0] dv;
    logic [NREQ-1:0]    m, r;

    // Reset state
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("reset ack/err", 32'({ack, err}), 32'(0));
    check("reset rd_data", 32'(rd_data), 32'(0));
    check("reset busy", 32'(busy), 32'(0));
    check("reset stack outs", 32'({stk_enable, stk_read_write, stk_data_in}), 32'(0));
    reset = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("idle stk_enable", 32'(stk_enable), 32'(0));
      check("idle busy", 32'(busy), 32'(0));
    end

    // Push/pop ordering and latency
    one(0, 1'b0, 16'h0002);
    one(0, 1'b0, 16'h0004);
    one(0, 1'b1, 16'h0000);
    one(0, 1'b1, 16'h0000);

    // Empty and full boundaries
    one(0, 1'b1, 16'h0000);
    for (int i = 0; i < DEPTH; i++) one(0, 1'b0, 16'(16'h0100 + i));
    one(0, 1'b0, 16'h00FF);
    one(0, 1'b1, 16'h0000);
    for (int i = 0; i < DEPTH - 2; i++) one(0, 1'b1, 16'h0000);
    one(3, 1'b1, 16'h0000);

    // Round robin: all four, twice, then a pair with the pointer at 2
    dv = {16'h0013, 16'h0012, 16'h0011, 16'h0010};
    run_set(4'b1111, 4'b0000, dv, 1'b0);
    run_set(4'b1111, 4'b0000, dv, 1'b0);
    one(1, 1'b1, 16'h0000);
    run_set(4'b0011, 4'b0011, '0, 1'b0);

    // Request fields altered after grant are ignored
    dv = '0;
    dv[1*DW +: DW] = 16'hBEEF;
    run_set(4'b0010, 4'b0000, dv, 1'b1);
    one(2, 1'b1, 16'h0000);

    // Reset in the middle of a pop's issue cycle
    @(posedge clk);
    #1;
    req_rw[0] = 1'b1;
    req[0]    = 1'b1;
    t = 0;
    while (!stk_enable && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("pop issue reached", 32'(stk_enable), 32'(1));
    reset = 1'b0;
    #1;
    check("mid-op reset ack/err", 32'({ack, err}), 32'(0));
    check("mid-op reset rd_data", 32'(rd_data), 32'(0));
    check("mid-op reset busy", 32'(busy), 32'(0));
    check("mid-op reset stack outs", 32'({stk_enable, stk_read_write, stk_data_in}), 32'(0));
    req = '0;
    repeat (2) begin
      @(negedge clk);
      check("held reset ack/err", 32'({ack, err}), 32'(0));
    end
    reset    = 1'b1;
    last_pop = '0;
    ptr_m    = 0;
    one(0, 1'b1, 16'h0000);

    // Randomized sets: push-heavy, pop-heavy, then uniform
    for (int it = 0; it < 150; it++) begin
      m  = 4'($urandom_range(1, 15));
      if (it < 50) r = 4'($urandom & $urandom);
      else if (it < 100) r = 4'($urandom | $urandom);
      else r = 4'($urandom);
      dv = {$urandom, $urandom};
      run_set(m, r, dv, $urandom_range(0, 3) == 0);
    end

    repeat (5) @(negedge clk);
    check("scoreboard drained", 32'(sb.size()), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
